// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - SDRAM command sequencer: ACTIVE/READ/WRITE/REFRESH/PRECHARGE/LOAD MODE
// Optional sticky command-error flag enabled by defining CMD_SEQ_ERR_EN.
module cmd_sequencer #(
  parameter int ROW_WIDTH  = 12,
  parameter int COL_WIDTH  = 9,
  parameter int BANK_WIDTH = 2,
  parameter int TRCD       = 2,
  parameter int CAS_LAT    = 2,
  parameter int BURST_LEN  = 4,
  parameter int TRC        = 7
) (
  input  logic                                     clk0,
  input  logic                                     reset,
  input  logic                                     do_refresh,
  input  logic                                     do_preacharge,
  input  logic                                     do_load_mod,
  input  logic                                     do_reada,
  input  logic                                     do_writea,
  input  logic [BANK_WIDTH+ROW_WIDTH+COL_WIDTH-1:0] addr,
  input  logic [ROW_WIDTH-1:0]                     mode_reg,
  output logic                                     sd_cs_n,
  output logic                                     sd_ras_n,
  output logic                                     sd_cas_n,
  output logic                                     sd_we_n,
  output logic [BANK_WIDTH-1:0]                    sd_ba,
  output logic [ROW_WIDTH-1:0]                     sd_addr,
  output logic                                     oe,
  output logic                                     rd_valid,
  output logic                                     busy
`ifdef CMD_SEQ_ERR_EN
  ,
  output logic                                     cmd_err
`endif
);

  typedef enum logic [3:0] {
    IDLE, ACT, RCD_WAIT, RD, WR, BURST, REF_WAIT, PRE, LMR
  } state_t;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_LMR  = 4'b0000;
  localparam logic [3:0] CMD_DESL = 4'b1111;

  localparam logic [3:0] T_RCD    = 4'(TRCD - 2);
  localparam logic [3:0] T_RD_BST = 4'(CAS_LAT + BURST_LEN - 1);
  localparam logic [3:0] T_WR_BST = 4'(BURST_LEN - 1);
  localparam logic [3:0] T_REF    = 4'(TRC - 1);
  localparam logic [3:0] BL4      = 4'(BURST_LEN);
  localparam logic [ROW_WIDTH-1:0] A10 = ROW_WIDTH'(1) << 10;

  state_t                state, state_nxt;
  logic [3:0]            timer, timer_nxt;
  logic                  is_rd;
  logic [BANK_WIDTH-1:0] bank_q;
  logic [COL_WIDTH-1:0]  col_q;
  logic [3:0]            cmd_q, cmd_nxt;
  logic [BANK_WIDTH-1:0] ba_nxt;
  logic [ROW_WIDTH-1:0]  addr_nxt;
  logic                  oe_nxt, rd_valid_nxt, busy_nxt;

  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;

  // State, timer, latched address and registered pins
  always_ff @(posedge clk0) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= 4'd0;
      is_rd    <= 1'b0;
      bank_q   <= '0;
      col_q    <= '0;
      cmd_q    <= CMD_DESL;
      sd_ba    <= '0;
      sd_addr  <= '0;
      oe       <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      cmd_q    <= cmd_nxt;
      sd_ba    <= ba_nxt;
      sd_addr  <= addr_nxt;
      oe       <= oe_nxt;
      rd_valid <= rd_valid_nxt;
      busy     <= busy_nxt;
      if (state == IDLE && state_nxt == ACT) begin
        is_rd  <= do_reada;
        bank_q <= addr[BANK_WIDTH+ROW_WIDTH+COL_WIDTH-1 -: BANK_WIDTH];
        col_q  <= addr[COL_WIDTH-1:0];
      end
    end
  end

  // Next state; the timer saturates at zero and steps advance only there
  always_comb begin
    state_nxt = state;
    timer_nxt = (timer != 4'd0) ? timer - 4'd1 : 4'd0;
    case (state)
      IDLE: begin
        if (do_refresh) begin
          state_nxt = REF_WAIT;
          timer_nxt = T_REF;
        end else if (do_preacharge) begin
          state_nxt = PRE;
        end else if (do_load_mod) begin
          state_nxt = LMR;
        end else if (do_reada || do_writea) begin
          state_nxt = ACT;
        end
      end
      ACT: begin
        if (TRCD == 1) begin
          state_nxt = is_rd ? RD : WR;
        end else begin
          state_nxt = RCD_WAIT;
          timer_nxt = T_RCD;
        end
      end
      RCD_WAIT: if (timer == 4'd0) state_nxt = is_rd ? RD : WR;
      RD: begin
        state_nxt = BURST;
        timer_nxt = T_RD_BST;
      end
      WR: begin
        state_nxt = BURST;
        timer_nxt = T_WR_BST;
      end
      BURST, REF_WAIT: if (timer == 4'd0) state_nxt = IDLE;
      PRE, LMR: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin values for the coming cycle; NOP cycles hold address and bank
  always_comb begin
    cmd_nxt  = CMD_NOP;
    ba_nxt   = sd_ba;
    addr_nxt = sd_addr;
    case (state_nxt)
      ACT: begin
        cmd_nxt  = CMD_ACT;
        ba_nxt   = addr[BANK_WIDTH+ROW_WIDTH+COL_WIDTH-1 -: BANK_WIDTH];
        addr_nxt = addr[COL_WIDTH +: ROW_WIDTH];
      end
      RD, WR: begin
        cmd_nxt  = (state_nxt == RD) ? CMD_RD : CMD_WR;
        ba_nxt   = bank_q;
        addr_nxt = A10 | ROW_WIDTH'(col_q);
      end
      PRE: begin
        cmd_nxt  = CMD_PRE;
        addr_nxt = A10;
      end
      LMR: begin
        cmd_nxt  = CMD_LMR;
        ba_nxt   = '0;
        addr_nxt = mode_reg;
      end
      REF_WAIT: if (state == IDLE) cmd_nxt = CMD_REF;
      default: cmd_nxt = CMD_NOP;
    endcase
    oe_nxt       = (state_nxt == WR) ||
                   (state_nxt == BURST && !is_rd && timer_nxt != 4'd0);
    rd_valid_nxt = state_nxt == BURST && is_rd &&
                   timer_nxt != 4'd0 && timer_nxt <= BL4;
    busy_nxt     = state_nxt != IDLE;
  end

`ifdef CMD_SEQ_ERR_EN
  logic any_pulse, multi_pulse;
  assign any_pulse   = do_refresh | do_preacharge | do_load_mod | do_reada | do_writea;
  assign multi_pulse = (do_refresh & (do_preacharge | do_load_mod | do_reada | do_writea)) |
                       (do_preacharge & (do_load_mod | do_reada | do_writea)) |
                       (do_load_mod & (do_reada | do_writea)) |
                       (do_reada & do_writea);

  always_ff @(posedge clk0) begin
    if (reset) begin
      cmd_err <= 1'b0;
    end else if ((state != IDLE && any_pulse) || (state == IDLE && multi_pulse)) begin
      cmd_err <= 1'b1;
    end
  end
`endif

endmodule
